// File: rtl/keypad_digit_entry.sv
// Keypad digit entry sequencer for the 10-key decimal keypad.
// Flow: 2-flop key synchronizer -> press/release debounce FSM -> BCD shift register ->
// VALID/ACK handoff to the consumer.
// Optional feature macro: KEYPAD_TIMEOUT_EN. When defined, a partial entry left idle for
// TIMEOUT_CYC cycles is discarded. When undefined, a partial entry is held indefinitely.
module keypad_digit_entry #(
    parameter int unsigned NDIG        = 4,
    parameter int unsigned DB_CYC      = 8,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic [9:0]          D,
    input  logic                CLR,
    input  logic                ACK,
    output logic [4*NDIG-1:0]   VALUE,
    output logic [3:0]          DCNT,
    output logic                KEY_STB,
    output logic                VALID,
    output logic                ERR
);

    localparam int unsigned VW = 4 * NDIG;
    localparam int unsigned CW = $clog2(DB_CYC + 1);

    // Reject unsupported configurations at elaboration time.
    if (NDIG < 1 || NDIG > 8 || DB_CYC < 2 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("keypad_digit_entry: unsupported parameter value");
    end

    typedef enum logic [2:0] {
        StIdle,
        StPressDb,
        StHeld,
        StRelDb,
        StFull
    } state_e;

    state_e          state_q;
    logic [9:0]      d_meta_q;
    logic [9:0]      ds_q;
    logic [9:0]      pat_q;
    logic [CW-1:0]   cnt_q;
    logic            ds_any;
    logic            pat_single;
    logic [3:0]      bcd;
    logic [VW-1:0]   bcd_ext;

`ifdef KEYPAD_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0]   idle_cnt_q;
`endif

    // Two-flop synchronizer for the asynchronous key lines.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            d_meta_q <= '0;
            ds_q     <= '0;
        end else begin
            d_meta_q <= D;
            ds_q     <= d_meta_q;
        end
    end

    // Decode the latched key pattern: single-key check and BCD encoding.
    always_comb begin
        ds_any     = |ds_q;
        pat_single = ($countones(pat_q) == 1);
        bcd        = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (pat_q[i]) begin
                bcd = 4'(i);
            end
        end
        bcd_ext = VW'(bcd);
    end

    // Entry FSM with registered outputs; FULL/ACK has priority over CLR.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= StIdle;
            pat_q      <= '0;
            cnt_q      <= '0;
            VALUE      <= '0;
            DCNT       <= '0;
            KEY_STB    <= 1'b0;
            VALID      <= 1'b0;
            ERR        <= 1'b0;
`ifdef KEYPAD_TIMEOUT_EN
            idle_cnt_q <= '0;
`endif
        end else begin
            KEY_STB <= 1'b0;
            if (state_q == StFull) begin
                if (ACK) begin
                    VALID   <= 1'b0;
                    DCNT    <= '0;
                    VALUE   <= '0;
                    ERR     <= 1'b0;
                    state_q <= StIdle;
                end
            end else if (CLR) begin
                VALUE   <= '0;
                DCNT    <= '0;
                ERR     <= 1'b0;
                cnt_q   <= '0;
                // A key still held must be released before it can count again.
                state_q <= ds_any ? StHeld : StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (ds_any) begin
                            pat_q   <= ds_q;
                            cnt_q   <= CW'(1);
                            state_q <= StPressDb;
                        end
                    end
                    StPressDb: begin
                        if (ds_q != pat_q) begin
                            state_q <= StIdle;
                        end else if (cnt_q == CW'(DB_CYC - 1)) begin
                            // This sample is the DB_CYC-th identical one.
                            if (pat_single) begin
                                VALUE   <= (VALUE << 4) | bcd_ext;
                                DCNT    <= DCNT + 4'd1;
                                KEY_STB <= 1'b1;
                            end else begin
                                ERR <= 1'b1;
                            end
                            state_q <= StHeld;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    StHeld: begin
                        if (!ds_any) begin
                            cnt_q   <= CW'(1);
                            state_q <= StRelDb;
                        end
                    end
                    StRelDb: begin
                        if (ds_any) begin
                            state_q <= StHeld;
                        end else if (cnt_q == CW'(DB_CYC - 1)) begin
                            if (DCNT == 4'(NDIG)) begin
                                VALID   <= 1'b1;
                                state_q <= StFull;
                            end else begin
                                state_q <= StIdle;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end

`ifdef KEYPAD_TIMEOUT_EN
            // Idle timer only runs for a partial entry with no key activity.
            if (state_q == StIdle && !CLR && !ds_any && DCNT != 4'd0 && DCNT < 4'(NDIG)) begin
                if (idle_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    VALUE      <= '0;
                    DCNT       <= '0;
                    idle_cnt_q <= '0;
                end else begin
                    idle_cnt_q <= idle_cnt_q + TW'(1);
                end
            end else begin
                idle_cnt_q <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Self-checking bench for keypad_digit_entry: directed vector table, hand-written corner
// sequences and randomized key operations against an operation-level reference model.
module tb_keypad_digit_entry;

    localparam int NDIG = 4;
    localparam int DB   = 8;
    localparam int TO   = 50;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic [9:0]  D;
    logic        CLR;
    logic        ACK;
    logic [15:0] VALUE;
    logic [3:0]  DCNT;
    logic        KEY_STB;
    logic        VALID;
    logic        ERR;

    keypad_digit_entry #(
        .NDIG        (NDIG),
        .DB_CYC      (DB),
        .TIMEOUT_CYC (TO)
    ) dut (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .D       (D),
        .CLR     (CLR),
        .ACK     (ACK),
        .VALUE   (VALUE),
        .DCNT    (DCNT),
        .KEY_STB (KEY_STB),
        .VALID   (VALID),
        .ERR     (ERR)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int stb_cnt  = 0;
    logic [3:0] last_digit = 4'd0;

    // Count every strobe and remember the digit it delivered.
    always @(negedge CLK) begin
        if (KEY_STB === 1'b1) begin
            stb_cnt++;
            last_digit = VALUE[3:0];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_outs(input string name, input int val, input int dcnt,
                              input int err, input int valid);
        check({name, " VALUE"}, int'(VALUE), val);
        check({name, " DCNT"},  int'(DCNT),  dcnt);
        check({name, " ERR"},   int'(ERR),   err);
        check({name, " VALID"}, int'(VALID), valid);
    endtask

    task automatic press(input logic [9:0] k, input int hold);
        D = k;
        repeat (hold) @(negedge CLK);
        D = '0;
        repeat (16) @(negedge CLK);
    endtask

    task automatic pulse(input bit do_clr, input bit do_ack);
        CLR = do_clr;
        ACK = do_ack;
        @(negedge CLK);
        CLR = 1'b0;
        ACK = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    typedef struct {
        logic [9:0]  keys;
        int          hold;
        bit          clr;
        bit          ack;
        int          stb;
        logic [15:0] value;
        int          dcnt;
        bit          err;
        bit          valid;
    } vec_t;

    vec_t vecs[11];

    // Operation-level reference model state.
    int m_val, m_dcnt, m_err, m_full;

    initial begin
        int s0;
        int lat;
        // keys, hold, clr, ack, stb, value, dcnt, err, valid
        vecs[0]  = '{10'h004, 20, 0, 0, 1, 16'h0002, 1, 0, 0};
        vecs[1]  = '{10'h000,  0, 1, 0, 0, 16'h0000, 0, 0, 0};
        vecs[2]  = '{10'h002, 12, 0, 0, 1, 16'h0001, 1, 0, 0};
        vecs[3]  = '{10'h200, 12, 0, 0, 1, 16'h0019, 2, 0, 0};
        vecs[4]  = '{10'h001, 12, 0, 0, 1, 16'h0190, 3, 0, 0};
        vecs[5]  = '{10'h020, 12, 0, 0, 1, 16'h1905, 4, 0, 1};
        vecs[6]  = '{10'h008, 12, 0, 0, 0, 16'h1905, 4, 0, 1};
        vecs[7]  = '{10'h000,  0, 0, 1, 0, 16'h0000, 0, 0, 0};
        vecs[8]  = '{10'h018, 12, 0, 0, 0, 16'h0000, 0, 1, 0};
        vecs[9]  = '{10'h080, 12, 0, 0, 1, 16'h0007, 1, 1, 0};
        vecs[10] = '{10'h000,  0, 1, 0, 0, 16'h0000, 0, 0, 0};

        // Reset with a key already down.
        RSTn = 1'b0; D = 10'h004; CLR = 1'b0; ACK = 1'b0;
        repeat (3) @(negedge CLK);
        check_outs("reset", int'(VALUE), 0, 0, 0);
        check("reset VALUE", int'(VALUE), 0);
        check("reset KEY_STB", int'(KEY_STB), 0);
        RSTn = 1'b1;

        for (int i = 0; i < 11; i++) begin
            s0 = stb_cnt;
            if (vecs[i].clr || vecs[i].ack) pulse(vecs[i].clr, vecs[i].ack);
            else press(vecs[i].keys, vecs[i].hold);
            check($sformatf("vec%0d stb", i), stb_cnt - s0, vecs[i].stb);
            check_outs($sformatf("vec%0d", i), int'(vecs[i].value), vecs[i].dcnt,
                       int'(vecs[i].err), int'(vecs[i].valid));
        end

        // Press-to-strobe latency: 2 sync + DB cycles.
        D = 10'h020;
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge CLK);
            if (KEY_STB === 1'b1) begin
                lat = i;
                break;
            end
        end
        check("latency", lat, 2 + DB);
        repeat (5) @(negedge CLK);
        D = '0;
        repeat (16) @(negedge CLK);
        check("latency VALUE", int'(VALUE), 16'h0005);
        pulse(1, 0);

        // Debounce boundary: DB-1 stable samples rejected, exactly DB accepted.
        s0 = stb_cnt;
        press(10'h080, DB - 1);
        check("short press stb", stb_cnt - s0, 0);
        press(10'h080, DB);
        check("exact press stb", stb_cnt - s0, 1);
        check("exact press DCNT", int'(DCNT), 1);
        pulse(1, 0);

        // Bounce on key 7 then stable.
        s0 = stb_cnt;
        for (int i = 0; i < 10; i++) begin
            D = (i % 2 == 0) ? 10'h080 : 10'h000;
            repeat (3) @(negedge CLK);
        end
        press(10'h080, 12);
        check("bounce stb", stb_cnt - s0, 1);
        check("bounce digit", int'(last_digit), 7);
        check("bounce DCNT", int'(DCNT), 1);
        pulse(1, 0);

        // CLR while key 6 is held after acceptance: no second digit on release.
        s0 = stb_cnt;
        D = 10'h040;
        repeat (14) @(negedge CLK);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        check("clr held DCNT", int'(DCNT), 0);
        repeat (5) @(negedge CLK);
        D = '0;
        repeat (16) @(negedge CLK);
        check("clr held stb", stb_cnt - s0, 1);
        check("clr held DCNT after", int'(DCNT), 0);

        // CLR during press debounce: key never registers.
        s0 = stb_cnt;
        D = 10'h040;
        repeat (4) @(negedge CLK);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        repeat (20) @(negedge CLK);
        D = '0;
        repeat (16) @(negedge CLK);
        check("clr early stb", stb_cnt - s0, 0);
        check("clr early DCNT", int'(DCNT), 0);

        // In FULL: CLR ignored, CLR+ACK behaves as ACK.
        press(10'h100, 12);
        press(10'h010, 12);
        press(10'h004, 12);
        press(10'h002, 12);
        pulse(1, 0);
        check_outs("full clr", 16'h8421, 4, 0, 1);
        pulse(1, 1);
        check_outs("full clr+ack", 0, 0, 0, 0);

        // Idle timeout on a partial entry.
        press(10'h002, 12);
        repeat (60) @(negedge CLK);
`ifdef KEYPAD_TIMEOUT_EN
        check("timeout DCNT", int'(DCNT), 0);
        check("timeout VALUE", int'(VALUE), 0);
`else
        check("no timeout DCNT", int'(DCNT), 1);
        check("no timeout VALUE", int'(VALUE), 1);
`endif
        pulse(0, 1);
        pulse(1, 0);

        // Randomized operations against the reference model.
        m_val = 0; m_dcnt = 0; m_err = 0; m_full = 0;
        for (int n = 0; n < 40; n++) begin
            int op, k1, k2, exp_stb;
            op = int'($urandom_range(0, 9));
            exp_stb = 0;
            s0 = stb_cnt;
            if (op <= 5) begin
                k1 = int'($urandom_range(0, 9));
                press(10'(1 << k1), 12);
                if (!m_full) begin
                    m_val = (m_val * 16 + k1) % 65536;
                    m_dcnt++;
                    exp_stb = 1;
                    if (m_dcnt == NDIG) m_full = 1;
                end
            end else if (op == 6) begin
                k1 = int'($urandom_range(0, 9));
                k2 = (k1 + 1 + int'($urandom_range(0, 8))) % 10;
                press(10'((1 << k1) | (1 << k2)), 12);
                if (!m_full) m_err = 1;
            end else if (op == 7) begin
                press(10'(1 << $urandom_range(0, 9)), DB - 3);
            end else if (op == 8) begin
                pulse(1, 0);
                if (!m_full) begin
                    m_val = 0; m_dcnt = 0; m_err = 0;
                end
            end else begin
                pulse(0, 1);
                if (m_full) begin
                    m_val = 0; m_dcnt = 0; m_err = 0; m_full = 0;
                end
            end
            check($sformatf("rnd%0d stb", n), stb_cnt - s0, exp_stb);
            check_outs($sformatf("rnd%0d op%0d", n, op), m_val, m_dcnt, m_err, m_full);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
